// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter and return-address sequencer for the RAT MCU.
//
// Produces the 10-bit fetch address for the program ROM. Each cycle the control
// unit commands hold, increment, jump, call, return, interrupt entry or
// interrupt return. Call and interrupt return addresses live in an internal
// LIFO return stack of DEPTH entries.
//
// Build option:
//   PC_STACK_GUARD_EN  defined   -> overflow drops the push and underflow
//                                   returns 0x000; both set sticky STACK_ERR.
//                      undefined -> circular stack: overflow overwrites the
//                                   oldest entry, underflow reads the wrapped
//                                   pointer; STACK_ERR stays 0.
module pc_sequencer #(
  parameter int         DEPTH    = 8,
  parameter logic [9:0] INTR_VEC = 10'h3FF
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   HOLD,
  input  logic [2:0]             CMD,
  input  logic [9:0]             IMMED,
  output logic [9:0]             PC_COUNT,
  output logic [$clog2(DEPTH):0] STACK_DEPTH,
  output logic                   STACK_FULL,
  output logic                   STACK_EMPTY,
  output logic                   STACK_ERR,
  output logic                   INT_ACTIVE
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
  localparam logic [9:0]       PC_ONE    = 10'd1;
  localparam logic [9:0]       PC_ZERO   = 10'd0;

  // Control-unit command encodings; 3'd7 is reserved and acts as NOP.
  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_JUMP = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;
  localparam logic [2:0] CMD_INTR = 3'd5;
  localparam logic [2:0] CMD_RETI = 3'd6;

  // Architectural state
  logic [9:0]       pc_r;
  logic [CNT_W-1:0] depth_r;
  logic [PTR_W-1:0] top_r;
  logic             full_r;
  logic             empty_r;
  logic             err_r;
  logic             int_r;
  logic [9:0]       stack_mem_r [DEPTH];

  // Next-state and request signals
  logic [9:0]       pc_nxt_s;
  logic             int_nxt_s;
  logic             push_req_s;
  logic             pop_req_s;
  logic [9:0]       push_data_s;
  logic [9:0]       pop_data_s;
  logic [9:0]       pop_pc_s;
  logic             wr_en_s;
  logic [PTR_W-1:0] top_nxt_s;
  logic [CNT_W-1:0] depth_nxt_s;
  logic             err_nxt_s;

  assign PC_COUNT    = pc_r;
  assign STACK_DEPTH = depth_r;
  assign STACK_FULL  = full_r;
  assign STACK_EMPTY = empty_r;
  assign STACK_ERR   = err_r;
  assign INT_ACTIVE  = int_r;

  // Top-of-stack read and the address a pop loads into the PC.
  always_comb begin
    pop_data_s = stack_mem_r[top_r - PTR_ONE];
`ifdef PC_STACK_GUARD_EN
    if (empty_r) begin
      pop_pc_s = PC_ZERO;
    end else begin
      pop_pc_s = pop_data_s;
    end
`else
    pop_pc_s = pop_data_s;
`endif
  end

  // Command decode: next PC, interrupt flag and stack push/pop requests.
  always_comb begin
    pc_nxt_s    = pc_r;
    int_nxt_s   = int_r;
    push_req_s  = 1'b0;
    pop_req_s   = 1'b0;
    push_data_s = pc_r;
    case (CMD)
      CMD_NOP: begin
        pc_nxt_s = pc_r;
      end
      CMD_INC: begin
        pc_nxt_s = pc_r + PC_ONE;
      end
      CMD_JUMP: begin
        pc_nxt_s = IMMED;
      end
      CMD_CALL: begin
        push_req_s  = 1'b1;
        push_data_s = pc_r + PC_ONE;
        pc_nxt_s    = IMMED;
      end
      CMD_RET: begin
        pop_req_s = 1'b1;
        pc_nxt_s  = pop_pc_s;
      end
      CMD_INTR: begin
        // No nesting: a second INTR while servicing one is a NOP.
        if (!int_r) begin
          push_req_s  = 1'b1;
          push_data_s = pc_r;
          pc_nxt_s    = INTR_VEC;
          int_nxt_s   = 1'b1;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      CMD_RETI: begin
        pop_req_s = 1'b1;
        pc_nxt_s  = pop_pc_s;
        int_nxt_s = 1'b0;
      end
      default: begin
        pc_nxt_s = pc_r;
      end
    endcase
  end

  // Stack pointer, depth and error bookkeeping for the requested push or pop.
  always_comb begin
    wr_en_s     = 1'b0;
    top_nxt_s   = top_r;
    depth_nxt_s = depth_r;
    err_nxt_s   = err_r;
    if (push_req_s) begin
`ifdef PC_STACK_GUARD_EN
      if (full_r) begin
        err_nxt_s = 1'b1;
      end else begin
        wr_en_s     = 1'b1;
        top_nxt_s   = top_r + PTR_ONE;
        depth_nxt_s = depth_r + CNT_ONE;
      end
`else
      // When full the write pointer sits on the oldest entry, so the push
      // overwrites it and the depth saturates.
      wr_en_s   = 1'b1;
      top_nxt_s = top_r + PTR_ONE;
      if (full_r) begin
        depth_nxt_s = depth_r;
      end else begin
        depth_nxt_s = depth_r + CNT_ONE;
      end
`endif
    end else if (pop_req_s) begin
`ifdef PC_STACK_GUARD_EN
      if (empty_r) begin
        err_nxt_s = 1'b1;
      end else begin
        top_nxt_s   = top_r - PTR_ONE;
        depth_nxt_s = depth_r - CNT_ONE;
      end
`else
      // The pointer always moves; depth never goes below zero.
      top_nxt_s = top_r - PTR_ONE;
      if (empty_r) begin
        depth_nxt_s = depth_r;
      end else begin
        depth_nxt_s = depth_r - CNT_ONE;
      end
`endif
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // PC, stack bookkeeping and flags: reset first, then hold, then command.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_r    <= PC_ZERO;
      depth_r <= CNT_ZERO;
      top_r   <= PTR_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      err_r   <= 1'b0;
      int_r   <= 1'b0;
    end else if (!HOLD) begin
      pc_r    <= pc_nxt_s;
      depth_r <= depth_nxt_s;
      top_r   <= top_nxt_s;
      full_r  <= (depth_nxt_s == DEPTH_CNT);
      empty_r <= (depth_nxt_s == CNT_ZERO);
      err_r   <= err_nxt_s;
      int_r   <= int_nxt_s;
    end
  end

  // Return-address storage; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (RST_N && !HOLD && wr_en_s) begin
      stack_mem_r[top_r] <= push_data_s;
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and return-address sequencer for the RAT MCU; it produces the 10-bit fetch address that drives the program ROM's address input. Each cycle it holds, increments, jumps, calls, returns, or vectors to the interrupt handler, as commanded by the control unit. Call and interrupt return addresses are kept in an internal LIFO return stack. The ROM read is registered, so the instruction at `PC_COUNT` appears on the ROM output one cycle after `PC_COUNT` changes.

## Interface
- `DEPTH`, default 8: return-stack entries; power of two, 2..64.
- `INTR_VEC`, default 10'h3FF: interrupt vector address.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `HOLD`  in  1  stall; when 1, all state is frozen and `CMD` is ignored.
- `CMD`  in  3  0 NOP, 1 INC, 2 JUMP, 3 CALL, 4 RET, 5 INTR, 6 RETI, 7 reserved (treated as NOP).
- `IMMED`  in  10  target address for JUMP and CALL.
- `PC_COUNT`  out  10  current fetch address (to ROM address).
- `STACK_DEPTH`  out  $clog2(DEPTH)+1  number of valid stack entries.
- `STACK_FULL`  out  1  `STACK_DEPTH == DEPTH`.
- `STACK_EMPTY`  out  1  `STACK_DEPTH == 0`.
- `STACK_ERR`  out  1  sticky overflow/underflow flag.
- `INT_ACTIVE`  out  1  set by INTR, cleared by RETI.

## Operation
- All outputs are registered or are decodes of registered state. Reset values: `PC_COUNT`=0, `STACK_DEPTH`=0, `STACK_EMPTY`=1, `STACK_FULL`=0, `STACK_ERR`=0, `INT_ACTIVE`=0. Stack contents are not reset.
- Priority: `RST_N`=0, then `HOLD`=1, then `CMD`.
- NOP: PC unchanged.
- INC: PC <= PC+1, modulo 1024 (0x3FF wraps to 0x000).
- JUMP: PC <= `IMMED`.
- CALL: push (PC+1) mod 1024; PC <= `IMMED`.
- RET: pop; PC <= popped value.
- INTR: push PC (the un-executed instruction's address); PC <= `INTR_VEC`; `INT_ACTIVE` <= 1.
- INTR while `INT_ACTIVE`=1: ignored; behaves as NOP (no nesting).
- RETI: pop; PC <= popped value; `INT_ACTIVE` <= 0.
- Stack: array plus a top pointer. A push writes at index `STACK_DEPTH`; a pop reads index `STACK_DEPTH`-1. Exactly one push or pop per cycle at most; there are no simultaneous push and pop.
- Overflow and underflow handling depends on `PC_STACK_GUARD_EN` (see Configuration).

## Timing
- Every command takes effect on the clock edge where it is sampled: `PC_COUNT`, depth, and flags update together, one edge after `CMD` is presented.
- The popped address is visible on `PC_COUNT` in the cycle after RET/RETI, with no extra bubble.
- ROM instruction latency from a `PC_COUNT` change is 1 cycle (ROM side); the control unit owns the fetch/execute phasing and issues `HOLD` accordingly.
- Reset mid-operation: the next edge with `RST_N`=0 forces the reset values regardless of `HOLD`/`CMD`. The stack is logically emptied.
- `STACK_ERR` clears only on reset.

## Configuration
- `PC_STACK_GUARD_EN` defined:
  - CALL/INTR when full: the push is dropped, but PC still loads the target; `STACK_ERR` <= 1.
  - RET/RETI when empty: PC <= 0x000, depth stays 0, `STACK_ERR` <= 1. RETI still clears `INT_ACTIVE`.
- `PC_STACK_GUARD_EN` undefined:
  - The stack is circular: a push when full overwrites the oldest entry and depth saturates at `DEPTH`.
  - A pop when empty returns the entry at the wrapped pointer and depth stays 0.
  - `STACK_ERR` is tied to 0.

## Test plan
- Reset, then 5×INC, then HOLD=1 with INC for 3 cycles -> `PC_COUNT` = 0x005 throughout the hold. Then INC at PC=0x3FF (reached via JUMP 0x3FF) -> 0x000.
- JUMP 0x120, CALL 0x200, CALL 0x300, RET, RET -> PC sequence 0x120, 0x200, 0x300, 0x201, 0x121; `STACK_DEPTH` goes 0,1,2,1,0.
- At PC=0x050: INTR, then INTR again, then RETI -> PC 0x3FF, 0x3FF (second INTR ignored, depth 1), 0x050; `INT_ACTIVE` goes 1,1,0.
- With guard: DEPTH+1 consecutive CALL 0x010 from PC=0x000, then RET with stack empty -> `STACK_FULL`=1, `STACK_ERR`=1 after the overflow; the empty RET gives PC=0x000. Without guard: `STACK_ERR` stays 0.
- RST_N low for 1 cycle while `STACK_DEPTH`=3 and `INT_ACTIVE`=1 -> all outputs return to their reset values on that edge; a following RET with guard sets `STACK_ERR`.
- CMD=7 at PC=0x0AA -> `PC_COUNT` and flags unchanged.
